// File: rtl/fan_pkg.sv
// -----------------------------------------------------------------------------
// fan_pkg
// Constants and types shared by the fan PWM generator and the fan PWM decoder.
//   FAN_PERIOD  : nominal PWM frame length in clk cycles (one frame per code)
//   FAN_TOL     : accepted period deviation, +/- cycles
//   FAN_TIMEOUT : cycles without a rising edge before the line counts as stuck
//   FAN_CNT_W   : counter width that holds FAN_TIMEOUT
//   fan_state_t : decoder state, IDLE / MEASURE
//   sat_duty()  : clamp a high-time count to an 8-bit speed code
// -----------------------------------------------------------------------------
package fan_pkg;

   localparam int unsigned FAN_PERIOD  = 256;
   localparam int unsigned FAN_TOL     = 4;
   localparam int unsigned FAN_TIMEOUT = 512;
   localparam int unsigned FAN_CNT_W   = 10;

   // Decoder state encoding, kept as plain constants for legacy tools.
   typedef logic [0:0] fan_state_t;
   localparam fan_state_t IDLE    = 1'b0;
   localparam fan_state_t MEASURE = 1'b1;

   // High times above 255 (frames up to PERIOD+TOL long) saturate.
   function automatic logic [7:0] sat_duty(input int unsigned cnt);
      return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
   endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// -----------------------------------------------------------------------------
// pwm_edge_sync
// Brings the asynchronous PWM line into the clk domain and flags rising edges.
// Build option: FAN_PWM_DEGLITCH_EN inserts a 3-sample majority filter after
// the synchronizer (rejects single-cycle pulses, adds 2 cycles of latency).
// Ports:
//   clk    in   system clock
//   arst   in   asynchronous reset, active-low
//   pwm_in in   asynchronous PWM input
//   level  out  synchronized (optionally filtered) line level
//   rise   out  one-cycle flag: level went 0 -> 1
// -----------------------------------------------------------------------------
module pwm_edge_sync
   import fan_pkg::*;
(
   input  logic clk,
   input  logic arst,
   input  logic pwm_in,
   output logic level,
   output logic rise
);

   logic sync_1;
   logic sync_2;
   logic filt;
   logic level_d;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= pwm_in;
         sync_2 <= sync_1;
      end
   end

`ifdef FAN_PWM_DEGLITCH_EN
   logic hist_1;
   logic hist_2;
   logic maj_q;

   // Majority of the current and two previous synchronized samples; a lone
   // sample of either polarity never wins the vote.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         hist_1 <= 1'b0;
         hist_2 <= 1'b0;
         maj_q  <= 1'b0;
      end else begin
         hist_1 <= sync_2;
         hist_2 <= hist_1;
         maj_q  <= (sync_2 & hist_1) | (sync_2 & hist_2) | (hist_1 & hist_2);
      end
   end

   assign filt = maj_q;
`else
   assign filt = sync_2;
`endif

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         level_d <= 1'b0;
      end else begin
         level_d <= filt;
      end
   end

   assign level = filt;
   assign rise  = filt & ~level_d;

endmodule

// File: rtl/fan_pwm_decoder.sv
// -----------------------------------------------------------------------------
// fan_pwm_decoder
// Measures high time and period of a PWM line between consecutive rising
// edges and recovers the 8-bit speed code; flags malformed or stuck lines.
// Build option: FAN_PWM_DEGLITCH_EN (see pwm_edge_sync) adds a deglitch filter.
// Parameters: PERIOD, TOL, TIMEOUT, CNT_W (CNT_W must hold TIMEOUT).
// Ports:
//   clk        in   system clock
//   arst       in   asynchronous reset, active-low
//   pwm_in     in   asynchronous PWM input
//   duty       out  last recovered speed code
//   duty_valid out  one-cycle pulse when duty is written
//   period_err out  one-cycle pulse when a period falls outside PERIOD+/-TOL
//   stuck      out  level; no rising edge seen for TIMEOUT cycles
// -----------------------------------------------------------------------------
module fan_pwm_decoder
   import fan_pkg::*;
#(
   parameter int unsigned PERIOD  = FAN_PERIOD,
   parameter int unsigned TOL     = FAN_TOL,
   parameter int unsigned TIMEOUT = FAN_TIMEOUT,
   parameter int unsigned CNT_W   = FAN_CNT_W
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       pwm_in,
   output logic [7:0] duty,
   output logic       duty_valid,
   output logic       period_err,
   output logic       stuck
);

   localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(PERIOD - TOL);
   localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(PERIOD + TOL);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic level;
   logic rise;

   pwm_edge_sync u_edge (
      .clk    (clk),
      .arst   (arst),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise)
   );

   fan_state_t       state_q;
   fan_state_t       state_d;
   logic [CNT_W-1:0] per_cnt_q;
   logic [CNT_W-1:0] per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] hi_cnt_d;
   logic [7:0]       duty_d;
   logic             duty_valid_d;
   logic             period_err_d;
   logic             stuck_d;
   logic             per_ok;

   assign per_ok = (per_cnt_q >= PER_MIN) && (per_cnt_q <= PER_MAX);

   always_comb begin
      state_d      = state_q;
      per_cnt_d    = per_cnt_q;
      hi_cnt_d     = hi_cnt_q;
      duty_d       = duty;
      duty_valid_d = 1'b0;
      period_err_d = 1'b0;
      stuck_d      = stuck;

      case (state_q)
         IDLE: begin
            // The frame in progress here is partial, so it is never reported.
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            if (rise) begin
               state_d   = MEASURE;
               per_cnt_d = CNT_ONE;
               hi_cnt_d  = CNT_ONE;
            end
         end
         MEASURE: begin
            if (rise) begin
               // A rise coinciding with a full TIMEOUT count lands here and
               // fails the period window.
               if (per_ok) begin
                  duty_d       = sat_duty(32'(hi_cnt_q));
                  duty_valid_d = 1'b1;
                  stuck_d      = 1'b0;
               end else begin
                  period_err_d = 1'b1;
               end
               per_cnt_d = CNT_ONE;
               hi_cnt_d  = CNT_ONE;
            end else if (per_cnt_q >= CNT_MAX) begin
               duty_d       = level ? 8'hFF : 8'h00;
               duty_valid_d = 1'b1;
               stuck_d      = 1'b1;
               state_d      = IDLE;
               per_cnt_d    = '0;
               hi_cnt_d     = '0;
            end else begin
               per_cnt_d = per_cnt_q + CNT_ONE;
               if (level && (hi_cnt_q < CNT_MAX)) begin
                  hi_cnt_d = hi_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= IDLE;
         per_cnt_q  <= '0;
         hi_cnt_q   <= '0;
         duty       <= 8'h00;
         duty_valid <= 1'b0;
         period_err <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_cnt_q  <= per_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
         duty       <= duty_d;
         duty_valid <= duty_valid_d;
         period_err <= period_err_d;
         stuck      <= stuck_d;
      end
   end

endmodule

// File: tb/tb_fan_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_fan_pwm_decoder
// Self-checking bench for fan_pwm_decoder: directed frames plus random frames,
// every cycle compared against a window-based reference model.
// -----------------------------------------------------------------------------
module tb_fan_pwm_decoder;
   import fan_pkg::*;

   localparam int unsigned PERIOD  = 256;
   localparam int unsigned TOL     = 4;
   localparam int unsigned TIMEOUT = 512;
   localparam int unsigned CNT_W   = 10;
`ifdef FAN_PWM_DEGLITCH_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic       clk    = 1'b0;
   logic       arst   = 1'b1;
   logic       pwm_in = 1'b0;
   logic [7:0] duty;
   logic       duty_valid;
   logic       period_err;
   logic       stuck;

   int checks   = 0;
   int failures = 0;

   fan_pwm_decoder #(
      .PERIOD  (PERIOD),
      .TOL     (TOL),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .duty_valid (duty_valid),
      .period_err (period_err),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Line level seen by the decoder is the input sample from LAT-1 edges back
   // (or a 3-sample vote); a frame is the list of levels between two rises.
   bit         hist [0:4];
   bit         lc;
   bit         lp;
   bit         meas;
   bit         win [$];
   logic [7:0] m_duty  = 8'h00;
   bit         m_valid;
   bit         m_err;
   bit         m_stuck;
   int         cyc     = 0;
   int         n_valid = 0;
   int         n_err   = 0;
   int         valid_at [$];

   function automatic bit level_now();
`ifdef FAN_PWM_DEGLITCH_EN
      return (int'(hist[2]) + int'(hist[3]) + int'(hist[4])) >= 2;
`else
      return hist[1];
`endif
   endfunction

   always @(posedge clk) begin : model
      bit r;
      int per_n;
      int hi_n;
      cyc++;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!arst) begin
         for (int i = 0; i < 5; i++) hist[i] = 1'b0;
         lc      = 1'b0;
         lp      = 1'b0;
         meas    = 1'b0;
         win.delete();
         m_duty  = 8'h00;
         m_stuck = 1'b0;
      end else begin
         r = lc && !lp;
         if (meas && r) begin
            per_n = win.size();
            hi_n  = 0;
            foreach (win[i]) hi_n += int'(win[i]);
            if (per_n >= int'(PERIOD - TOL) && per_n <= int'(PERIOD + TOL)) begin
               m_duty  = (hi_n > 255) ? 8'hFF : 8'(hi_n);
               m_valid = 1'b1;
               m_stuck = 1'b0;
            end else begin
               m_err = 1'b1;
            end
            win.delete();
         end else if (meas && win.size() == int'(TIMEOUT)) begin
            m_duty  = lc ? 8'hFF : 8'h00;
            m_valid = 1'b1;
            m_stuck = 1'b1;
            meas    = 1'b0;
            win.delete();
         end else if (!meas && r) begin
            meas = 1'b1;
         end
         if (meas) win.push_back(lc);
         for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = pwm_in;
         lp = lc;
         lc = level_now();
      end
      #1;
      check("outs", {duty, duty_valid, period_err, stuck}, {m_duty, m_valid, m_err, m_stuck});
      if (duty_valid === 1'b1) begin
         n_valid++;
         valid_at.push_back(cyc);
      end
      if (period_err === 1'b1) n_err++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v);
      @(negedge clk);
      pwm_in = v;
   endtask

   task automatic hold(input bit v, input int n);
      for (int i = 0; i < n; i++) drive(v);
   endtask

   // One frame: hi cycles high then low up to per; gl flips one cycle (-1: none).
   // re returns the edge index at which the frame's first high is sampled.
   task automatic frame(input int hi, input int per, input int gl, output int re);
      re = 0;
      for (int i = 0; i < per; i++) begin
         drive(((i < hi) ? 1'b1 : 1'b0) ^ ((i == gl) ? 1'b1 : 1'b0));
         if (i == 0) re = cyc + 1;
      end
   endtask

   initial begin
      int re;
      int r2;
      int v0;
      int e0;
      int per;
      int hi;
      int gl;

      // Reset values
      #2 arst = 1'b0;
      #1;
      check("rst_duty", 32'(duty), 32'd0);
      check("rst_flags", {duty_valid, period_err, stuck}, 32'd0);
      repeat (3) @(negedge clk);
      arst = 1'b1;
      hold(1'b0, 10);

      // 64/192 frames: first report LAT after the second rise, then every 256
      valid_at.delete();
      v0 = n_valid;
      r2 = 0;
      for (int f = 0; f < 4; f++) begin
         frame(64, 256, -1, re);
         if (f == 1) r2 = re;
      end
      check("a_count", n_valid - v0, 3);
      check("a_first_lat", (valid_at.size() > 0) ? valid_at[0] - r2 : -1, LAT);
      check("a_spacing", (valid_at.size() > 1) ? valid_at[1] - valid_at[0] : -1, 256);
      check("a_duty", 32'(duty), 32'd64);

      // Speed 4
      v0 = n_valid;
      e0 = n_err;
      for (int f = 0; f < 4; f++) frame(4, 256, -1, re);
      check("b_duty", 32'(duty), 32'd4);
      check("b_err", n_err - e0, 0);
      check("b_count", n_valid - v0, 4);

      // Line held low: timeout 512 cycles after the last rise
      frame(64, 256, -1, re);
      valid_at.delete();
      hold(1'b0, 600);
      check("c_to_lat", (valid_at.size() > 0) ? valid_at[0] - re : -1, LAT + 512);
      check("c_duty", 32'(duty), 32'd0);
      check("c_stuck", 32'(stuck), 32'd1);

      // Line held high; stuck clears only after a full valid frame
      hold(1'b1, 600);
      check("d_duty", 32'(duty), 32'd255);
      check("d_stuck", 32'(stuck), 32'd1);
      v0 = n_valid;
      hold(1'b0, 50);
      frame(64, 256, -1, re);
      check("d_quiet", n_valid - v0, 0);
      check("d_stuck_hold", 32'(stuck), 32'd1);
      frame(64, 256, -1, re);
      check("d_stuck_clr", 32'(stuck), 32'd0);
      check("d_duty64", 32'(duty), 32'd64);

      // Period 300 rejected, period 259 accepted
      e0 = n_err;
      frame(64, 300, -1, re);
      frame(100, 259, -1, re);
      check("e_err", n_err - e0, 1);
      check("e_duty_hold", 32'(duty), 32'd64);
      frame(64, 256, -1, re);
      check("e_259", 32'(duty), 32'd100);
      check("e_err2", n_err - e0, 1);

      // Reset mid-frame
      hold(1'b1, 64);
      hold(1'b0, 36);
      arst = 1'b0;
      #1;
      check("f_rst", {duty, duty_valid, period_err, stuck}, 32'd0);
      hold(1'b0, 3);
      arst = 1'b1;
      v0 = n_valid;
      hold(1'b0, 100);
      frame(80, 256, -1, re);
      check("f_first_quiet", n_valid - v0, 0);
      frame(80, 256, -1, re);
      check("f_second", 32'(duty), 32'd80);
      check("f_count", n_valid - v0, 1);

      // 128-high frames with a one-cycle low glitch at high-cycle 50
      e0 = n_err;
      for (int f = 0; f < 3; f++) frame(128, 256, 50, re);
`ifdef FAN_PWM_DEGLITCH_EN
      check("g_err", n_err - e0, 0);
      check("g_duty", 32'(duty), 32'd128);
`else
      check("g_err_seen", 32'(n_err > e0), 32'd1);
`endif

      // Rise exactly when the count reaches TIMEOUT: period error, not stuck
      frame(64, 256, -1, re);
      frame(10, 512, -1, re);
      e0 = n_err;
      v0 = n_valid;
      frame(64, 256, -1, re);
      check("h_err", n_err - e0, 1);
      check("h_valid", n_valid - v0, 0);
      check("h_stuck", 32'(stuck), 32'd0);

      // Random frames, checked cycle by cycle against the model
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(99, 0) < 75) begin
            per = $urandom_range(PERIOD + TOL + 3, PERIOD - TOL - 3);
         end else begin
            per = $urandom_range(620, 20);
         end
         hi = $urandom_range(per - 1, 1);
         gl = ($urandom_range(9, 0) == 0) ? $urandom_range(per - 1, 0) : -1;
         frame(hi, per, gl, re);
      end
      hold(1'b0, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fan_pwm_decoder.md
# fan_pwm_decoder

Receive-side counterpart of the fan PWM generator. The block samples a PWM waveform such as the fan controller's `pwm_data`, measures the high time and period between consecutive rising edges, and recovers the 8-bit speed code that produced it. It sits on the smart-house status path, so the controller can read back actual fan drive and detect a stuck or malformed PWM line.

## Interface
- `PERIOD`, 256: nominal PWM frame length in clk cycles (one frame per 8-bit code).
- `TOL`, 4: accepted period deviation, ± cycles.
- `TIMEOUT`, 512: cycles without a rising edge before the line is declared stuck.
- `CNT_W`, 10: counter width; must hold `TIMEOUT`.
- `clk`  in  1  system clock.
- `arst`  in  1  asynchronous reset, active-low.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  8  last recovered speed code.
- `duty_valid`  out  1  one-cycle pulse when `duty` is written.
- `period_err`  out  1  one-cycle pulse when a measured period falls outside `PERIOD±TOL`.
- `stuck`  out  1  level; line has had no rising edge for `TIMEOUT` cycles.

## Operation
- Front end: `pwm_in` passes through a 2-FF synchronizer, then a registered copy drives the rising-edge detect `rise = s & ~s_d`.
- States:
  - IDLE: counters held at 0. On `rise`, go to MEASURE and load `per_cnt=1`, `hi_cnt=1`.
  - MEASURE, each cycle without `rise`: `per_cnt++`; `hi_cnt++` when the synchronized level is high.
    - At the next `rise`, `per_cnt` equals the exact period and `hi_cnt` the exact high count.
    - If `|per_cnt−PERIOD| ≤ TOL`: `duty = min(hi_cnt,255)` (saturating), `duty_valid=1`, `stuck=0`.
    - Otherwise: `period_err=1` and `duty` is held.
    - In both cases, reload `per_cnt=1`, `hi_cnt=1` and stay in MEASURE.
    - If `per_cnt` reaches `TIMEOUT` before a `rise`: `duty = level ? 8'hFF : 8'h00`, `duty_valid=1`, `stuck=1`, go to IDLE.
- `stuck` stays set until the next valid measurement. A `rise` alone, including the one that re-enters MEASURE from IDLE, does not clear it.
- The first partial frame after reset or after a timeout is never reported.
- Counters saturate at `TIMEOUT` and never wrap.

## Timing
- Reset values: `duty=0`, `duty_valid=0`, `period_err=0`, `stuck=0`, state IDLE, synchronizer flops 0.
- `arst` asserted mid-frame aborts the measurement immediately. No pulse is produced.
- Latency: a `pwm_in` rise sampled at clk edge k gives `rise` during cycle k+1→k+2. `duty`/`duty_valid`/`period_err` are registered at edge k+2.
- `duty_valid` and `period_err` are mutually exclusive, each exactly one cycle wide.
- `rise` in the same cycle that `per_cnt` reaches `TIMEOUT`: `rise` wins and is treated as a period evaluation, which fails and pulses `period_err`.

## Configuration
- `FAN_PWM_DEGLITCH_EN` defined: a 3-sample majority filter sits between the synchronizer and the edge detect.
  - Single-cycle pulses on `pwm_in` are rejected.
  - Latency grows by 2 cycles, to edge k+4.
- Undefined: no filter, and the latency is as stated under Timing.

## Structure
- Shared package `fan_pkg`:
  - state enum `{IDLE, MEASURE}`;
  - default `PERIOD`/`TOL`/`TIMEOUT` constants, shared with the generator.
- Sub-module `pwm_edge_sync`: synchronizer, optional deglitch filter, registered level and `rise` output.

## Test plan
- 64 cycles high / 192 low, repeated ×4:
  - first `duty_valid` appears 2 cycles after the second rising edge, with `duty=64`;
  - then one pulse every 256 cycles.
- Generator driven at speed 4 (4 high / 252 low): `duty=4` each frame; `period_err` never asserts.
- `pwm_in` held low 600 cycles after a valid frame: 512 cycles after the last `rise`, `duty=0`, `duty_valid` pulses, `stuck=1`. Held high instead: `duty=255`, `stuck=1`. `stuck` clears only after the next valid frame.
- Frame of period 300 after a `duty=64` frame: `period_err` pulses and `duty` stays 64. Period 259: accepted.
- `arst` low for 3 cycles mid-frame: all outputs return to reset values. The first frame after release produces no pulse; the second reports a correct value.
- With `FAN_PWM_DEGLITCH_EN`, 128-high frames with a 1-cycle low glitch at high-cycle 50: `duty=128` and no `period_err`. Without the macro, the same stimulus produces `period_err`.
